cmd_s_pn: RTL and testbench

//  Serial-to-parallel receiver for the SD host CMD line, the receive end of the command path.
//  It is armed after a command is sent, then hunts for the card's start bit within a response window.
//  It shifts in a 48-bit (R1/R3/R6/R7) or 136-bit (R2) response and checks CRC7, direction and end bit.
//  It presents the frame right-aligned on a parallel bus with a one-cycle completion strobe.

---
 rtl/sd_cmd_pkg.sv | 22 ++
 rtl/crc7_serial.sv | 19 +
 rtl/cmd_s_pn.sv | 130 +++++++++++++
 tb/tb_cmd_s_pn.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/sd_cmd_pkg.sv
// rtl/sd_cmd_pkg.sv - shared constants, receive states and CRC7 step for the SD CMD path
package sd_cmd_pkg;

   localparam logic [6:0] CRC7_POLY = 7'h09;
   localparam int         SHORT_LEN = 48;
   localparam int         LONG_LEN  = 136;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_START = 2'd1,
      RECEIVE    = 2'd2,
      DONE       = 2'd3
   } rx_state_e;

   // One serial step of G(x) = x^7 + x^3 + 1, MSB first.
   function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic din);
      logic fb;
      fb = crc[6] ^ din;
      return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
   endfunction

endpackage

// File: rtl/crc7_serial.sv
// rtl/crc7_serial.sv - serial CRC7 accumulator, shared by the CMD transmit and receive paths
module crc7_serial (
   input  logic       clk,
   input  logic       reset,
   input  logic       clr,
   input  logic       en,
   input  logic       din,
   output logic [6:0] crc
);
   import sd_cmd_pkg::*;

   always_ff @(posedge clk) begin
      if (reset || clr)
         crc <= 7'h00;
      else if (en)
         crc <= crc7_next(crc, din);
   end

endmodule

// File: rtl/cmd_s_pn.sv
// rtl/cmd_s_pn.sv - CMD line response receiver: start-bit hunt, deserialise, CRC7/frame checks
module cmd_s_pn #(
   parameter int SHORT_LEN      = 48,
   parameter int LONG_LEN       = 136,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cmd_in,
   input  logic                start_rx,
   input  logic                resp_long,
   input  logic                crc_check_en,
   output logic [LONG_LEN-1:0] response_o,
   output logic                resp_valid,
   output logic                crc_err,
   output logic                frame_err,
   output logic                timeout_err,
   output logic                busy
);
   import sd_cmd_pkg::*;

   localparam int              TMO_W        = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]      SHORT_TOP    = 8'(SHORT_LEN - 2);
   localparam logic [7:0]      LONG_TOP     = 8'(LONG_LEN - 2);
   localparam logic [7:0]      SHORT_START  = 8'(SHORT_LEN - 1);
   localparam logic [7:0]      LONG_START   = 8'(LONG_LEN - 1);
   localparam logic [7:0]      SHORT_CRC_HI = 8'(SHORT_LEN - 1);
   localparam logic [7:0]      LONG_CRC_HI  = 8'(LONG_LEN - 9);
   localparam logic [7:0]      CRC_LO       = 8'd8;

   rx_state_e           state;
   logic                long_q;
   logic                chk_q;
   logic [7:0]          bit_cnt;
   logic [TMO_W-1:0]    tmo_cnt;
   logic [LONG_LEN-1:0] shift;
   logic [LONG_LEN-1:0] shift_nxt;
   logic [7:0]          frame_idx;
   logic [7:0]          crc_hi;
   logic                sampling;
   logic                crc_clr;
   logic                crc_en;
   logic                dir_bit;
   logic [6:0]          crc;

   // Frame index of the bit on cmd_in this cycle; the start bit is sampled in WAIT_START.
   always_comb begin
      frame_idx = bit_cnt;
      if (state == WAIT_START)
         frame_idx = long_q ? LONG_START : SHORT_START;
      crc_hi    = long_q ? LONG_CRC_HI : SHORT_CRC_HI;
      sampling  = (state == RECEIVE) || (state == WAIT_START && !cmd_in);
      crc_en    = sampling && (frame_idx >= CRC_LO) && (frame_idx <= crc_hi);
      crc_clr   = (state == IDLE) && start_rx;
      shift_nxt = {shift[LONG_LEN-2:0], cmd_in};
      dir_bit   = long_q ? shift_nxt[LONG_LEN-2] : shift_nxt[SHORT_LEN-2];
   end

   crc7_serial u_crc (
      .clk   (clk),
      .reset (reset),
      .clr   (crc_clr),
      .en    (crc_en),
      .din   (cmd_in),
      .crc   (crc)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         long_q      <= 1'b0;
         chk_q       <= 1'b0;
         bit_cnt     <= 8'd0;
         tmo_cnt     <= '0;
         shift       <= '0;
         response_o  <= '0;
         crc_err     <= 1'b0;
         frame_err   <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_rx) begin
                  long_q      <= resp_long;
                  chk_q       <= crc_check_en;
                  bit_cnt     <= 8'd0;
                  tmo_cnt     <= '0;
                  shift       <= '0;
                  crc_err     <= 1'b0;
                  frame_err   <= 1'b0;
                  timeout_err <= 1'b0;
                  state       <= WAIT_START;
               end
            end
            WAIT_START: begin
               if (!cmd_in) begin
                  shift   <= shift_nxt;
                  bit_cnt <= long_q ? LONG_TOP : SHORT_TOP;
                  state   <= RECEIVE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
                  if (tmo_cnt == TMO_LAST) begin
                     timeout_err <= 1'b1;
                     response_o  <= '0;
                     state       <= DONE;
                  end
               end
            end
            RECEIVE: begin
               shift <= shift_nxt;
               // End bit: the CRC already covers up to bit 8, bits 7..1 are the received CRC field.
               if (bit_cnt == 8'd0) begin
                  response_o <= shift_nxt;
                  crc_err    <= chk_q && (crc != shift_nxt[7:1]);
                  frame_err  <= dir_bit || !cmd_in;
                  state      <= DONE;
               end else begin
                  bit_cnt <= bit_cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign resp_valid = (state == DONE);
   assign busy       = (state == WAIT_START) || (state == RECEIVE);

endmodule

// File: tb/tb_cmd_s_pn.sv
// tb/tb_cmd_s_pn.sv - randomized self-checking bench for cmd_s_pn against a frame-level model
module tb_cmd_s_pn;

   logic         clk = 1'b0;
   logic         reset;
   logic         cmd_in;
   logic         start_rx;
   logic         resp_long;
   logic         crc_check_en;
   logic [135:0] response_o;
   logic         resp_valid;
   logic         crc_err;
   logic         frame_err;
   logic         timeout_err;
   logic         busy;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   cmd_s_pn dut (
      .clk          (clk),
      .reset        (reset),
      .cmd_in       (cmd_in),
      .start_rx     (start_rx),
      .resp_long    (resp_long),
      .crc_check_en (crc_check_en),
      .response_o   (response_o),
      .resp_valid   (resp_valid),
      .crc_err      (crc_err),
      .frame_err    (frame_err),
      .timeout_err  (timeout_err),
      .busy         (busy)
   );

   task automatic check_val(input string tag, input logic [135:0] got, input logic [135:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Remainder of M(x)*x^7 divided by x^7+x^3+1, message = frame bits hi..8.
   function automatic logic [6:0] crc_ref(input logic [135:0] f, input int hi);
      logic [7:0] r;
      r = 8'h00;
      for (int i = hi; i >= 1; i--) begin
         r = {r[6:0], (i >= 8) ? f[i] : 1'b0};
         if (r[7]) r = r ^ 8'h89;
      end
      return r[6:0];
   endfunction

   function automatic logic [135:0] build_short(input logic [5:0] idx, input logic [31:0] arg);
      logic [135:0] f;
      f = '0;
      f[47:0] = {1'b0, 1'b0, idx, arg, 7'h00, 1'b1};
      f[7:1] = crc_ref(f, 47);
      return f;
   endfunction

   function automatic logic [135:0] build_long();
      logic [135:0] f;
      f = {$urandom, $urandom, $urandom, $urandom, $urandom};
      f[135:128] = 8'h3F;
      f[7:0] = 8'h01;
      f[7:1] = crc_ref(f, 127);
      return f;
   endfunction

   task automatic arm(input bit lng, input bit chk);
      @(negedge clk);
      start_rx     = 1'b1;
      resp_long    = lng;
      crc_check_en = chk;
      cmd_in       = 1'b1;
      @(negedge clk);
      start_rx     = 1'b0;
      resp_long    = 1'($urandom_range(0, 1));
      crc_check_en = 1'($urandom_range(0, 1));
   endtask

   task automatic run_frame(input string tag, input logic [135:0] f, input bit lng,
                            input bit chk, input int idle);
      int           n;
      logic [135:0] exp_resp;
      logic         exp_crc;
      logic         exp_frm;
      bit           early;
      bit           busy_lo;
      n        = lng ? 136 : 48;
      exp_resp = lng ? f : (f & {88'h0, {48{1'b1}}});
      exp_crc  = chk && (crc_ref(f, lng ? 127 : 47) != f[7:1]);
      exp_frm  = f[n-2] | ~f[0];
      early    = 1'b0;
      busy_lo  = 1'b0;
      arm(lng, chk);
      repeat (idle) begin
         if (resp_valid) early = 1'b1;
         if (!busy) busy_lo = 1'b1;
         @(negedge clk);
      end
      for (int i = n - 1; i >= 0; i--) begin
         if (resp_valid) early = 1'b1;
         if (!busy) busy_lo = 1'b1;
         cmd_in   = f[i];
         start_rx = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      start_rx = 1'b0;
      cmd_in   = 1'b1;
      check_val({tag, " early_valid"}, early, 0);
      check_val({tag, " busy_gap"}, busy_lo, 0);
      check_val({tag, " resp_valid"}, resp_valid, 1);
      check_val({tag, " response"}, response_o, exp_resp);
      check_val({tag, " crc_err"}, crc_err, exp_crc);
      check_val({tag, " frame_err"}, frame_err, exp_frm);
      check_val({tag, " timeout_err"}, timeout_err, 0);
      @(negedge clk);
      check_val({tag, " valid_pulse"}, resp_valid, 0);
      check_val({tag, " busy_after"}, busy, 0);
      repeat (3) @(negedge clk);
      check_val({tag, " hold_resp"}, response_o, exp_resp);
      check_val({tag, " hold_flags"}, {crc_err, frame_err, timeout_err}, {exp_crc, exp_frm, 1'b0});
   endtask

   task automatic run_timeout();
      int cycles;
      arm(1'($urandom_range(0, 1)), 1'b1);
      cycles = 0;
      while (!resp_valid && cycles < 200) begin
         @(negedge clk);
         cycles++;
      end
      check_val("tmo cycles", cycles, 64);
      check_val("tmo timeout_err", timeout_err, 1);
      check_val("tmo response", response_o, 0);
      check_val("tmo other_errs", {crc_err, frame_err}, 0);
      check_val("tmo busy", busy, 0);
      @(negedge clk);
      check_val("tmo valid_pulse", resp_valid, 0);
   endtask

   task automatic run_reset_abort(input logic [135:0] f);
      bit seen;
      arm(1'b0, 1'b1);
      repeat (3) @(negedge clk);
      for (int i = 47; i >= 20; i--) begin
         cmd_in = f[i];
         if (i == 20) reset = 1'b1;
         @(negedge clk);
      end
      check_val("rst busy", busy, 0);
      check_val("rst valid", resp_valid, 0);
      reset  = 1'b0;
      cmd_in = 1'b1;
      seen   = 1'b0;
      repeat (80) begin
         @(negedge clk);
         if (resp_valid) seen = 1'b1;
      end
      check_val("rst no_valid", seen, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [135:0] f1;
      logic [135:0] f;
      int           hi;
      reset        = 1'b1;
      cmd_in       = 1'b1;
      start_rx     = 1'b0;
      resp_long    = 1'b0;
      crc_check_en = 1'b1;
      repeat (3) @(negedge clk);
      check_val("reset response", response_o, 0);
      check_val("reset flags", {resp_valid, crc_err, frame_err, timeout_err, busy}, 0);
      reset = 1'b0;

      f1 = '0;
      f1[47:0] = 48'h11_00000900_67;
      run_frame("r1_cmd17", f1, 1'b0, 1'b1, 5);
      check_val("r1_cmd17 model_crc", crc_ref(f1, 47), f1[7:1]);
      run_frame("r1_flip", f1 ^ (136'h1 << 16), 1'b0, 1'b1, 5);

      f = build_short(6'h3F, $urandom);
      f[7:1] = 7'h7F;
      run_frame("r3_nocrc", f, 1'b0, 1'b0, 2);

      run_timeout();

      f = build_long();
      run_frame("r2_good", f, 1'b1, 1'b1, 7);
      f[0] = 1'b0;
      run_frame("r2_endbit", f, 1'b1, 1'b1, 1);

      f = build_short(6'($urandom), $urandom);
      run_frame("idle63", f, 1'b0, 1'b1, 63);
      run_frame("idle0", f, 1'b0, 1'b1, 0);

      run_reset_abort(f1);
      run_frame("after_rst", f1, 1'b0, 1'b1, 5);

      for (int k = 0; k < 24; k++) begin
         bit lng;
         bit chk;
         lng = 1'($urandom_range(0, 1));
         chk = 1'($urandom_range(0, 3) != 0);
         f   = lng ? build_long() : build_short(6'($urandom), $urandom);
         hi  = lng ? 127 : 45;
         case ($urandom_range(0, 4))
            1: f[$urandom_range(8, hi)] ^= 1'b1;
            2: f[0] = 1'b0;
            3: f[lng ? 134 : 46] = 1'b1;
            4: f[7:1] = f[7:1] ^ 7'($urandom_range(1, 127));
            default: ;
         endcase
         run_frame($sformatf("rnd%0d", k), f, lng, chk, $urandom_range(0, 40));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
